// File: rtl/gray_img_pkg.sv
// Shared widths, default frame geometry and FSM state type for the gray-image
// processing blocks.
package gray_img_pkg;
    localparam int PIX_W     = 8;
    localparam int GRAD_W    = 11;
    localparam int MAG_W     = 12;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 464;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;
endpackage

// File: rtl/gray_line_buffer.sv
// One-line delay: o_dout is the pixel written DEPTH enables ago (read-before-write).
module gray_line_buffer
    import gray_img_pkg::*;
#(
    parameter int DEPTH = IMG_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [PIX_W-1:0] i_din,
    output logic [PIX_W-1:0] o_dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PIX_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_ptr;

    assign o_dout = r_mem[r_ptr];

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
        end
    end
endmodule

// File: rtl/gray_sobel_3x3.sv
// Sobel edge magnitude over a streamed gray frame: two line buffers, a 3x3
// window and a three-stage arithmetic pipe, with a FLUSH phase to emit the tail.
module gray_sobel_3x3
    import gray_img_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_gray_valid,
    input  logic [PIX_W-1:0] i_gray,
    output logic             o_edge_valid,
    output logic [PIX_W-1:0] o_edge,
    output logic             o_edge_sof,
    output logic             o_edge_eol,
    output logic             o_busy,
    output logic             o_err_overrun
);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int FW = $clog2(IMG_W + 1);

    function automatic logic signed [GRAD_W-1:0] px(input logic [PIX_W-1:0] p);
        return $signed({{(GRAD_W - PIX_W){1'b0}}, p});
    endfunction

    function automatic logic [GRAD_W-1:0] abs_f(input logic signed [GRAD_W-1:0] v);
        return v[GRAD_W-1] ? $unsigned(-v) : $unsigned(v);
    endfunction

    function automatic logic [PIX_W-1:0] sat_f(input logic [MAG_W-1:0] m);
        return (m > MAG_W'(255)) ? '1 : m[PIX_W-1:0];
    endfunction

    state_t                    r_state, w_state_nxt;
    logic [XW-1:0]             r_x, r_ox;
    logic [YW-1:0]             r_y, r_oy;
    logic [FW-1:0]             r_fcnt;
    logic                      w_accept, w_inject, w_adv, w_last_px, w_last_inj, w_out_k;
    logic                      w_border;
    logic [PIX_W-1:0]          w_pix, w_lb1, w_lb2;
    logic [MAG_W-1:0]          w_mag;
    logic                      vld_p0, adv_p0, vld_p1, vld_p2;
    logic [PIX_W-1:0]          r_tap_p0 [3];
    logic [PIX_W-1:0]          r_win_p1 [3][3];
    logic signed [GRAD_W-1:0]  r_gx_p2, r_gy_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (w_accept && w_last_px) w_state_nxt = FLUSH;
            FLUSH:   if (w_last_inj) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        w_accept = 1'b0;
        w_inject = 1'b0;
        o_busy   = 1'b0;
        case (r_state)
            RUN:     w_accept = i_gray_valid;
            FLUSH:   begin
                w_inject = 1'b1;
                o_busy   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_adv      = w_accept | w_inject;
    assign w_pix      = w_accept ? i_gray : '0;
    assign w_last_px  = (r_x == XW'(IMG_W - 1)) && (r_y == YW'(IMG_H - 1));
    assign w_last_inj = (r_fcnt == FW'(IMG_W));
    // The first IMG_W+1 pixels of a frame only prime the window.
    assign w_out_k    = w_inject ||
                        (w_accept && ((r_y > YW'(1)) || ((r_y == YW'(1)) && (r_x != '0))));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x           <= '0;
            r_y           <= '0;
            r_fcnt        <= '0;
            o_err_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_x == XW'(IMG_W - 1)) begin
                    r_x <= '0;
                    r_y <= (r_y == YW'(IMG_H - 1)) ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
            if (w_inject) begin
                r_fcnt <= w_last_inj ? '0 : r_fcnt + FW'(1);
                if (w_last_inj) begin
                    r_x <= '0;
                    r_y <= '0;
                end
            end
            if (o_busy && i_gray_valid) begin
                o_err_overrun <= 1'b1;
            end
        end
    end

    gray_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_adv),
        .i_din  (w_pix),
        .o_dout (w_lb1)
    );

    gray_line_buffer #(.DEPTH(IMG_W)) u_lb2 (
        .clk    (clk),
        .rst    (rst),
        .i_en   (w_adv),
        .i_din  (w_lb1),
        .o_dout (w_lb2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            adv_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p0 <= w_out_k;
            adv_p0 <= w_adv;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Capture the column taps (y-2, y-1, y) on the accepting edge
    always_ff @(posedge clk) begin
        r_tap_p0[0] <= w_lb2;
        r_tap_p0[1] <= w_lb1;
        r_tap_p0[2] <= w_pix;
    end

    // Stage 1: shift the new column into the window; centre is r_win_p1[1][1]
    always_ff @(posedge clk) begin
        if (adv_p0) begin
            for (int r = 0; r < 3; r++) begin
                r_win_p1[r][0] <= r_win_p1[r][1];
                r_win_p1[r][1] <= r_win_p1[r][2];
                r_win_p1[r][2] <= r_tap_p0[r];
            end
        end
    end

    // Stage 2: gradients
    always_ff @(posedge clk) begin
        r_gx_p2 <= (px(r_win_p1[0][2]) + (px(r_win_p1[1][2]) <<< 1) + px(r_win_p1[2][2]))
                 - (px(r_win_p1[0][0]) + (px(r_win_p1[1][0]) <<< 1) + px(r_win_p1[2][0]));
        r_gy_p2 <= (px(r_win_p1[2][0]) + (px(r_win_p1[2][1]) <<< 1) + px(r_win_p1[2][2]))
                 - (px(r_win_p1[0][0]) + (px(r_win_p1[0][1]) <<< 1) + px(r_win_p1[0][2]));
    end

    assign w_mag    = MAG_W'(abs_f(r_gx_p2)) + MAG_W'(abs_f(r_gy_p2));
    assign w_border = (r_ox == '0) || (r_ox == XW'(IMG_W - 1)) ||
                      (r_oy == '0) || (r_oy == YW'(IMG_H - 1));

    // Stage 3: magnitude, saturation, border mask and output tagging
    always_ff @(posedge clk) begin
        if (rst) begin
            o_edge_valid <= 1'b0;
            o_edge       <= '0;
            o_edge_sof   <= 1'b0;
            o_edge_eol   <= 1'b0;
            r_ox         <= '0;
            r_oy         <= '0;
        end else begin
            o_edge_valid <= vld_p2;
            o_edge       <= w_border ? '0 : sat_f(w_mag);
            o_edge_sof   <= vld_p2 && (r_ox == '0) && (r_oy == '0);
            o_edge_eol   <= vld_p2 && (r_ox == XW'(IMG_W - 1));
            if (vld_p2) begin
                if (r_ox == XW'(IMG_W - 1)) begin
                    r_ox <= '0;
                    r_oy <= (r_oy == YW'(IMG_H - 1)) ? '0 : r_oy + YW'(1);
                end else begin
                    r_ox <= r_ox + XW'(1);
                end
            end
        end
    end
endmodule
